// File: rtl/xor_parity_acc.sv
// rtl/xor_parity_acc.sv - serial parity and ones-count accumulator over fixed-length frames
//
// Folds FRAME_LEN accepted bits into one parity bit and a ones count, then
// holds the result on a valid/ready port until it is taken.
//
// Optional feature macro: XOR_PAR_ODD_EN
//   defined   -> out_parity is odd parity (inverted XOR of the frame bits)
//   undefined -> out_parity is even parity (plain XOR of the frame bits)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear of partial frame and pending result
//   in_valid   in   in_bit is valid this cycle
//   in_bit     in   serial data bit
//   in_ready   out  a bit is accepted this cycle if in_valid is high
//   out_valid  out  frame result is valid
//   out_ready  in   downstream takes the result
//   out_parity out  frame parity (registered)
//   out_ones   out  number of ones in the frame (registered)
//   bit_cnt    out  bits accepted in the current frame

module xor_parity_acc #(
    parameter int FRAME_LEN = 8,
    localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_ones,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

`ifdef XOR_PAR_ODD_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] oones_q, oones_d;

    logic             accept;
    logic             acc_nxt;
    logic [CNT_W-1:0] ones_nxt;

    // Handshake flags come from the state register alone, so neither
    // in_valid nor out_ready can reach them combinationally.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);

    assign accept   = in_valid && in_ready;
    assign acc_nxt  = acc_q ^ in_bit;
    assign ones_nxt = ones_q + CNT_W'(in_bit);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        oones_d = oones_q;

        if (clr) begin
            state_d = S_IDLE;
            acc_d   = 1'b0;
            ones_d  = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
            oones_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        acc_d  = acc_nxt;
                        ones_d = ones_nxt;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            // Result registers load on the same edge that
                            // accepts the final bit of the frame.
                            state_d = S_DONE;
                            par_d   = acc_nxt ^ PAR_INV;
                            oones_d = ones_nxt;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        acc_d   = 1'b0;
                        ones_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = 1'b0;
                    ones_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= 1'b0;
            ones_q  <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            oones_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            oones_q <= oones_d;
        end
    end

    assign out_parity = par_q;
    assign out_ones   = oones_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_xor_parity_acc.sv
// tb/tb_xor_parity_acc.sv - scoreboard testbench for xor_parity_acc

module tb_xor_parity_acc;

    localparam int FL    = 8;
    localparam int CNT_W = $clog2(FL + 1);

`ifdef XOR_PAR_ODD_EN
    localparam int PAR_INV = 1;
`else
    localparam int PAR_INV = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_parity;
    logic [CNT_W-1:0] out_ones;
    logic [CNT_W-1:0] bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        int par;
        int ones;
    } exp_t;

    exp_t exp_q[$];

    xor_parity_acc #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_ones   (out_ones),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the next rising edge whenever valid and
    // ready are both high mid-cycle and clr is not overriding it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_parity", int'(out_parity), e.par);
                check("sb_ones", int'(out_ones), e.ones);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents one bit after 'gap' idle cycles and returns just after the
    // edge that accepted it.
    task automatic send_bit(input logic b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_bit   = b;
        t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Reference model: parity is the ones count modulo two.
    task automatic send_frame(input logic [7:0] bits, input int gap,
                              input bit push, input bit chk_cnt);
        int   ones;
        exp_t e;
        logic [7:0] bv;
        bv   = bits;
        ones = 0;
        for (int i = 0; i < FL; i++) ones += int'(bv[i]);
        e.ones = ones;
        e.par  = (ones % 2) ^ PAR_INV;
        if (push) exp_q.push_back(e);
        for (int i = FL - 1; i >= 0; i--) begin
            send_bit(bv[i], gap);
            if (chk_cnt) check("bit_cnt_step", int'(bit_cnt), FL - i);
        end
    endtask

    initial begin
        int t;
        logic [7:0] rb;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_parity", int'(out_parity), 0);
        check("rst_out_ones", int'(out_ones), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        rst_n = 1'b1;

        // Back-to-back frame, single-cycle out_valid
        out_ready = 1'b1;
        send_frame(8'b10110000, 0, 1'b1, 1'b0);
        check("t1_out_valid_rise", int'(out_valid), 1);
        check("t1_bit_cnt_done", int'(bit_cnt), FL);
        step();
        check("t1_out_valid_fall", int'(out_valid), 0);
        check("t1_in_ready", int'(in_ready), 1);
        check("t1_bit_cnt_zero", int'(bit_cnt), 0);

        // All ones with backpressure
        out_ready = 1'b0;
        send_frame(8'b11111111, 0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_valid", int'(out_valid), 1);
            check("t2_hold_in_ready", int'(in_ready), 0);
            check("t2_hold_ones", int'(out_ones), 8);
            check("t2_hold_parity", int'(out_parity), PAR_INV);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t2_in_ready_after", int'(in_ready), 1);
        check("t2_valid_after", int'(out_valid), 0);

        // Gapped input
        send_frame(8'b10110000, 1, 1'b1, 1'b1);
        step();

        // Reset mid-frame
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        check("t4_cnt_before_rst", int'(bit_cnt), 4);
        rst_n = 1'b0;
        #1;
        check("t4_rst_in_ready", int'(in_ready), 1);
        check("t4_rst_out_valid", int'(out_valid), 0);
        check("t4_rst_bit_cnt", int'(bit_cnt), 0);
        check("t4_rst_ones", int'(out_ones), 0);
        step();
        rst_n = 1'b1;
        send_frame(8'b11000001, 0, 1'b1, 1'b0);
        step();

        // clr together with the final accept
        for (int i = 0; i < FL - 1; i++) send_bit(1'b1, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t5_no_valid", int'(out_valid), 0);
        check("t5_bit_cnt", int'(bit_cnt), 0);
        send_frame(8'b00000110, 0, 1'b1, 1'b1);
        step();

        // clr in DONE together with out_ready
        out_ready = 1'b0;
        send_frame(8'b11100000, 0, 1'b0, 1'b0);
        check("t6_done_valid", int'(out_valid), 1);
        clr       = 1'b1;
        out_ready = 1'b1;
        step();
        clr = 1'b0;
        check("t6_valid_clr", int'(out_valid), 0);
        check("t6_in_ready_clr", int'(in_ready), 1);
        check("t6_ones_clr", int'(out_ones), 0);
        check("t6_parity_clr", int'(out_parity), 0);
        check("t6_bit_cnt_clr", int'(bit_cnt), 0);

        // Randomized frames, gaps and backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, int'($urandom_range(0, 2)), 1'b1, 1'b0);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_parity_acc.md
# xor_parity_acc

Serial parity accumulator sitting directly downstream of the `dexor` XOR cell. It consumes the cell's output bit stream one bit per accepted handshake and folds each frame of `FRAME_LEN` bits into a single parity bit by running XOR. It also produces a ones count per frame. Results are presented on a valid/ready output port for the next stage or for bench checking.

## Interface
- `FRAME_LEN`, default 8: bits per frame; legal range 2..255.
- `CNT_W` is a derived localparam, not overridable: `$clog2(FRAME_LEN+1)`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear; discards any partial frame and any pending result.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit, typically `dexor.y`.
- `in_ready`  out  1  block accepts a bit this cycle.
- `out_valid`  out  1  frame result is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_parity`  out  1  XOR of all bits in the frame (even parity; see Configuration).
- `out_ones`  out  CNT_W  number of 1 bits in the frame.
- `bit_cnt`  out  CNT_W  bits accepted so far in the current frame.

## Operation
- Three states:
  - IDLE: `bit_cnt`=0, accumulator=0, `in_ready`=1.
  - ACC: partial frame held, `in_ready`=1.
  - DONE: result held, `in_ready`=0, `out_valid`=1.
- An accept is `in_valid && in_ready` at a rising edge. On each accept:
  - `acc <= acc ^ in_bit`
  - `ones <= ones + in_bit`
  - `bit_cnt <= bit_cnt + 1`
- Transitions:
  - IDLE→ACC on accept when `FRAME_LEN` > 1.
  - ACC→DONE on the accept that makes `bit_cnt` equal `FRAME_LEN`.
  - DONE→IDLE on `out_valid && out_ready`.
- `out_parity` and `out_ones` are registered. They are loaded on the edge that enters DONE and are stable while `out_valid`=1.
- In DONE, `in_bit` and `in_valid` are ignored. No bit is lost, because `in_ready`=0.
- `bit_cnt` counts 0..FRAME_LEN-1 in IDLE/ACC. In DONE it reads `FRAME_LEN`, then returns to 0 on the output handshake. It never wraps past `FRAME_LEN`.
- `out_ones` saturates by construction, since its maximum is `FRAME_LEN` and that fits in `CNT_W`.
- `clr`=1 at an edge forces IDLE and zeroes the accumulator, `ones`, `bit_cnt`, `out_valid`, `out_parity` and `out_ones`. `clr` overrides a simultaneous accept or output handshake.
- `in_ready` and `out_valid` are decoded from the state register only; there is no combinational path from `in_valid` or `out_ready`.

## Timing
- Reset (`rst_n`=0) takes effect asynchronously:
  - state=IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `out_parity`=0
  - `out_ones`=0
  - `bit_cnt`=0
- Reset release is synchronous to `clk` in the integration. The first accept can occur on the first rising edge with `rst_n`=1.
- Latency: `out_valid` rises on the same edge that accepts the last bit of the frame, so it is visible one cycle after that bit is presented.
- Result turnaround:
  - The handshake edge drops `out_valid` and raises `in_ready`.
  - The next frame's first bit is accepted no earlier than the following edge.
  - Peak throughput is one frame per `FRAME_LEN`+1 cycles.
- Gaps in `in_valid` stall accumulation with no state change.
- Backpressure (`out_ready`=0) holds DONE indefinitely with outputs stable.
- If reset is asserted mid-frame or in DONE, the partial frame and the pending result are lost. After release, the block restarts in IDLE.

## Configuration
- Macro `XOR_PAR_ODD_EN`:
  - Defined: `out_parity` = ~(XOR of frame bits), i.e. odd parity. The reset value of `out_parity` stays 0.
  - Undefined (default): `out_parity` = XOR of frame bits, i.e. even parity.
  - `out_ones` is unaffected either way.

## Test plan
- Reset, then `FRAME_LEN`=8 with bits 1,0,1,1,0,0,0,0 presented back-to-back, `out_ready`=1 → `out_valid` for exactly 1 cycle, `out_parity`=1, `out_ones`=3. With `XOR_PAR_ODD_EN` defined → `out_parity`=0.
- Frame of all 1s with `out_ready`=0 for 5 cycles → DONE held; `out_parity`=0, `out_ones`=8, `in_ready`=0 throughout. Handshake → `in_ready`=1 on the next cycle.
- Same bits as the first test, with `in_valid` deasserted every other cycle → same result. `bit_cnt` increments only on accepts.
- `rst_n` pulsed low after 4 accepted bits → all outputs at reset values immediately. A following full 8-bit frame of 1,1,0,0,0,0,0,1 gives `out_parity`=1, `out_ones`=3.
- `clr` asserted together with the 8th accept → no `out_valid`, `bit_cnt`=0, and the next frame is accumulated from scratch.
- `clr` asserted in DONE together with `out_ready`=1 → `out_valid`=0 next cycle, state IDLE, `out_ones`=0.
